// File: rtl/cf_math_pkg.sv
// Index-width arithmetic shared by every block that addresses a requester.
// No latency or backpressure: compile-time helpers only.
package cf_math_pkg;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/dummy_arb_pkg.sv
// Shared types for the round-robin arbiter.
// No latency or backpressure: type definitions only.
package dummy_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dummy_rr_pick.sv
// Round-robin pick: lowest active index at or above ptr_i, else lowest overall.
// Purely combinational, no backpressure.
module dummy_rr_pick #(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                empty_o
);

    logic [NumReq-1:0]   req_masked;
    logic [IdxWidth-1:0] cnt_masked, cnt_all;
    logic                empty_masked, empty_all;

    always_comb begin
        req_masked = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            req_masked[i] = req_i[i] && (i >= int'(ptr_i));
        end
    end

    lzc #(.WIDTH(NumReq), .MODE(1'b0)) u_lzc_masked (
        .in_i    (req_masked),
        .cnt_o   (cnt_masked),
        .empty_o (empty_masked)
    );

    lzc #(.WIDTH(NumReq), .MODE(1'b0)) u_lzc_all (
        .in_i    (req_i),
        .cnt_o   (cnt_all),
        .empty_o (empty_all)
    );

    // Nothing at or above the pointer: wrap to the lowest active requester.
    assign idx_o   = empty_masked ? cnt_all : cnt_masked;
    assign empty_o = empty_all;

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros, MODE=1 leading.
// Purely combinational, no backpressure; cnt_o is 0 when empty_o is set.
module lzc #(
    parameter int unsigned WIDTH = 2,
    parameter bit          MODE  = 1'b0,
    localparam int unsigned CntWidth = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    always_comb begin
        cnt_o = '0;
        if (!MODE) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CntWidth'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CntWidth'(int'(WIDTH) - 1 - i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/dummy_rr_arbiter.sv
// Round-robin N:1 arbiter with optional lock-in of the chosen requester.
// Zero-cycle req_i->req_o in IDLE; holds the selection while gnt_i is low (LockIn=1).
module dummy_rr_arbiter
    import dummy_arb_pkg::*;
#(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          LockIn    = 1'b1,
    localparam int unsigned IdxWidth = cf_math_pkg::idx_width(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq-1:0][DataWidth-1:0] data_i,
    output logic [NumReq-1:0]                gnt_o,
    output logic                             req_o,
    input  logic                             gnt_i,
    output logic [DataWidth-1:0]             data_o,
    output logic [IdxWidth-1:0]              idx_o
);

    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [IdxWidth-1:0] pick_idx, sel_idx;
    logic                pick_empty, sel_vld, hs;

    dummy_rr_pick #(.NumReq(NumReq)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .empty_o (pick_empty)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        sel_vld    = 1'b0;
        sel_idx    = '0;
        // Reset masks the outputs so an in-flight lock never produces a grant.
        if (!rst_i) begin
            if (state_q == LOCKED) begin
                sel_vld = 1'b1;
                sel_idx = lock_idx_q;
            end else if (!pick_empty) begin
                sel_vld = 1'b1;
                sel_idx = pick_idx;
            end
        end
        hs = sel_vld & gnt_i;
        if (hs) begin
            ptr_d = (sel_idx == IdxWidth'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
        end
        if (state_q == IDLE) begin
            if (LockIn && sel_vld && !gnt_i) begin
                state_d    = LOCKED;
                lock_idx_d = sel_idx;
            end
        end else if (gnt_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[sel_idx] = 1'b1;
    end

    assign req_o  = sel_vld;
    assign idx_o  = sel_idx;
    assign data_o = sel_vld ? data_i[sel_idx] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A locked requester must keep its request up until granted.
    a_lock_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == LOCKED) |-> req_i[lock_idx_q]);

endmodule

// File: tb/tb_dummy_rr_arbiter.sv
// Bench for dummy_rr_arbiter: a lock-in instance and a LockIn=0 instance,
// expected outputs queued at drive time and compared when sampled.
module tb_dummy_rr_arbiter;
    import dummy_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req_a = '0, req_b = '0;
    logic             gnt_a = 1'b0, gnt_b = 1'b0;
    logic [3:0][31:0] data_in;
    logic [3:0]       gnt_o_a, gnt_o_b;
    logic             req_o_a, req_o_b;
    logic [31:0]      data_o_a, data_o_b;
    logic [1:0]       idx_o_a, idx_o_b;

    typedef struct {
        bit         inst;
        string      tag;
        logic       req;
        logic [1:0] idx;
        logic [3:0] gnt;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dummy_rr_arbiter #(.NumReq(4), .DataWidth(32), .LockIn(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .data_i(data_in), .gnt_o(gnt_o_a),
        .req_o(req_o_a), .gnt_i(gnt_a), .data_o(data_o_a), .idx_o(idx_o_a)
    );

    dummy_rr_arbiter #(.NumReq(4), .DataWidth(32), .LockIn(1'b0)) dut_nl (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .data_i(data_in), .gnt_o(gnt_o_b),
        .req_o(req_o_b), .gnt_i(gnt_b), .data_o(data_o_b), .idx_o(idx_o_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        if (e.inst) begin
            chk({e.tag, ".req_o"},  32'(req_o_b), 32'(e.req));
            chk({e.tag, ".idx_o"},  32'(idx_o_b), 32'(e.idx));
            chk({e.tag, ".gnt_o"},  32'(gnt_o_b), 32'(e.gnt));
            chk({e.tag, ".data_o"}, data_o_b, e.dat);
        end else begin
            chk({e.tag, ".req_o"},  32'(req_o_a), 32'(e.req));
            chk({e.tag, ".idx_o"},  32'(idx_o_a), 32'(e.idx));
            chk({e.tag, ".gnt_o"},  32'(gnt_o_a), 32'(e.gnt));
            chk({e.tag, ".data_o"}, data_o_a, e.dat);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at negedge.
    task automatic step(input string tag, input bit inst, input logic [3:0] req, input logic gnt,
                        input logic exp_req, input logic [1:0] exp_idx, input logic [3:0] exp_gnt);
        exp_t e;
        if (inst) begin req_b = req; gnt_b = gnt; end
        else      begin req_a = req; gnt_a = gnt; end
        e.inst = inst;
        e.tag  = tag;
        e.req  = exp_req;
        e.idx  = exp_idx;
        e.gnt  = exp_gnt;
        e.dat  = exp_req ? (32'hA000_0000 | 32'(exp_idx)) : 32'd0;
        sb_q.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data_in[i] = 32'hA000_0000 | 32'(i);

        // Reset state with no requests.
        #2;
        chk("rst.req_o", 32'(req_o_a), 32'd0);
        chk("rst.gnt_o", 32'(gnt_o_a), 32'd0);
        chk("rst.idx_o", 32'(idx_o_a), 32'd0);
        chk("rst.data_o", data_o_a, 32'd0);
        chk("rst.ptr", 32'(dut.ptr_q), 32'd0);
        chk("rst.state", 32'(dut.state_q), 32'(IDLE));
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full rotation with every requester active.
        step("rot0", 0, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001);
        chk("rot0.ptr", 32'(dut.ptr_q), 32'd1);
        step("rot1", 0, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010);
        step("rot2", 0, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100);
        step("rot3", 0, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000);
        chk("rot.ptr_wrap", 32'(dut.ptr_q), 32'd0);

        // Bring ptr to 2, then wrap-around selection.
        step("pre_wrap", 0, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010);
        chk("pre_wrap.ptr", 32'(dut.ptr_q), 32'd2);
        step("wrap", 0, 4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001);
        chk("wrap.ptr", 32'(dut.ptr_q), 32'd1);

        // Empty request with ready high: nothing happens.
        step("empty", 0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        chk("empty.ptr", 32'(dut.ptr_q), 32'd1);
        chk("empty.state", 32'(dut.state_q), 32'(IDLE));

        // Lock on index 2 and hold against a higher-priority newcomer.
        step("lock0", 0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000);
        chk("lock0.state", 32'(dut.state_q), 32'(LOCKED));
        step("lock1", 0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000);
        step("lock2", 0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000);
        step("lock3", 0, 4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000);
        step("lock4", 0, 4'b0110, 1'b0, 1'b1, 2'd2, 4'b0000);
        step("lock_rel", 0, 4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100);
        chk("lock_rel.state", 32'(dut.state_q), 32'(IDLE));
        chk("lock_rel.ptr", 32'(dut.ptr_q), 32'd3);

        // Lock on index 3, then asynchronous reset mid-handshake.
        step("lock3_0", 0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000);
        chk("lock3_0.state", 32'(dut.state_q), 32'(LOCKED));
        gnt_a = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst.req_o", 32'(req_o_a), 32'd0);
        chk("arst.gnt_o", 32'(gnt_o_a), 32'd0);
        chk("arst.idx_o", 32'(idx_o_a), 32'd0);
        chk("arst.ptr", 32'(dut.ptr_q), 32'd0);
        chk("arst.state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        #1;
        req_a = '0;
        gnt_a = 1'b0;
        rst   = 1'b0;
        step("post_rst", 0, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000);
        chk("post_rst.ptr", 32'(dut.ptr_q), 32'd0);

        // No lock-in: selection follows req_i every cycle.
        step("nl0", 1, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000);
        chk("nl0.state", 32'(dut_nl.state_q), 32'(IDLE));
        step("nl1", 1, 4'b1001, 1'b0, 1'b1, 2'd0, 4'b0000);
        chk("nl1.ptr", 32'(dut_nl.ptr_q), 32'd0);
        step("nl2", 1, 4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001);
        chk("nl2.ptr", 32'(dut_nl.ptr_q), 32'd1);
        step("nl3", 1, 4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000);
        chk("nl3.ptr", 32'(dut_nl.ptr_q), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dummy_rr_arbiter.md
DUMMY_RR_ARBITER -- requirements
Module: dummy_rr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of requesters (legal range 1..32).
REQ-002 SHALL have parameter DataWidth, default 32, payload width per requester.
REQ-003 SHALL have parameter LockIn, default 1, hold the chosen requester until its handshake completes.
REQ-004 SHALL derive localparam IdxWidth = cf_math_pkg::idx_width(NumReq).
REQ-005 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_i  input  NumReq  per-requester valid.
REQ-008 SHALL have port data_i  input  NumReq x DataWidth  per-requester payload.
REQ-009 SHALL have port gnt_o  output  NumReq  per-requester grant (one-hot or zero).
REQ-010 SHALL have port req_o  output  1  downstream valid.
REQ-011 SHALL have port gnt_i  input  1  downstream ready.
REQ-012 SHALL have port data_o  output  DataWidth  payload of the selected requester.
REQ-013 SHALL have port idx_o  output  IdxWidth  index of the selected requester.

Function
REQ-014 SHALL hold a round-robin pointer ptr_q (IdxWidth bits): the requester with the highest priority.
REQ-015 SHALL select the lowest-index active requester at index >= ptr_q; if none exists, SHALL select the lowest-index active requester overall (wrap-around).
REQ-016 SHALL perform the selection combinationally (zero-cycle latency from req_i to req_o/idx_o in IDLE), via trailing-zero counts.
REQ-017 SHALL drive req_o = |req_i in IDLE, and req_o = 1 in LOCKED.
REQ-018 SHALL drive gnt_o[idx_o] = req_o & gnt_i; all other gnt_o bits SHALL be 0.
REQ-019 SHALL drive data_o = data_i[idx_o]; data_o and idx_o SHALL be 0 when req_o = 0.
REQ-020 SHALL implement FSM states IDLE and LOCKED.
- IDLE -> LOCKED: req_o & ~gnt_i & LockIn; the selected index is stored in lock_idx_q.
- LOCKED -> IDLE: gnt_i.
- In LOCKED: idx_o = lock_idx_q regardless of new higher-priority requests.
REQ-021 SHALL, on every completed handshake (req_o & gnt_i), set ptr_q = idx_o + 1, wrapping to 0 when idx_o = NumReq-1.
REQ-022 SHALL leave ptr_q unchanged in cycles without a handshake.
REQ-023 SHALL, when LockIn = 0, never enter LOCKED; selection is re-evaluated each cycle.
REQ-024 SHALL flag, via assertion only, req_i[lock_idx_q] deasserting while LOCKED (protocol violation); RTL SHALL still return to IDLE on the next gnt_i.
REQ-025 SHALL, when NumReq = 1, reduce to a pass-through with idx_o = 0 and ptr_q constant 0.
REQ-026 SHALL treat req_i = 0 in IDLE as empty: req_o = 0, gnt_o = 0, and no state change.

Reset
REQ-027 SHALL, while rst_i = 1, force state = IDLE, ptr_q = 0 and lock_idx_q = 0, independent of clk_i.
REQ-028 SHALL, on reset asserted mid-handshake in LOCKED, abort the handshake: state = IDLE, no grant, and ptr_q = 0.
REQ-029 SHALL keep req_o, gnt_o, data_o and idx_o at 0 while rst_i = 1 and req_i = 0.

Structure
REQ-030 SHALL place the state enum arb_state_e {IDLE, LOCKED} in shared package dummy_arb_pkg.
REQ-031 SHALL use cf_math_pkg for index-width arithmetic, with no local duplicates.
REQ-032 SHALL contain one sub-module, dummy_rr_pick, which instantiates two common_cells lzc (MODE = 0, trailing) on the masked and unmasked request vectors and outputs the index and an empty flag.

Verification
REQ-033 SHALL cover: NumReq=4, reset, req_i=4'b1111, gnt_i=1 for 4 cycles -> idx_o sequence 0,1,2,3 and ptr_q back to 0.
REQ-034 SHALL cover: ptr_q=2, req_i=4'b0011, gnt_i=1 -> idx_o=0 (wrap), then ptr_q=1.
REQ-035 SHALL cover: req_i=4'b0100, gnt_i=0 for 3 cycles, then req_i=4'b0101 -> idx_o stays 2 (LOCKED); gnt_i=1 -> gnt_o=4'b0100, state IDLE.
REQ-036 SHALL cover: LOCKED on idx 3, assert rst_i for 1 cycle -> req_o=0, gnt_o=0, ptr_q=0 immediately (asynchronous).
REQ-037 SHALL cover: req_i=0, gnt_i=1 -> req_o=0, gnt_o=0, ptr_q unchanged.
REQ-038 SHALL cover: LockIn=0, req_i=4'b1000 then 4'b1001 with gnt_i=0 and ptr_q=0 -> idx_o switches 3 -> 0.
